uart_rx_frame_ctrl: RTL and testbench
=====================================

Name: uart_rx_frame_ctrl

Overview:
- Frame controller for the UART receive path, directly downstream of the edge/bit counter.
- Consumes `edge_cnt`/`bit_cnt`, drives the counter's `enable` and `new_frame`, and majority-votes the serial line at mid-bit.
- Deserializes 8 data bits LSB-first, checks the optional parity bit and the stop bit, and presents the received byte to the RX interface logic.

Parameters:
- PRESCALE_W, 6, width of `prescale` and `edge_cnt`.
- DATA_WIDTH, 8, data bits per frame. Fixed at 8 to match the counter's `bit_cnt` wrap points; other values are unsupported.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- RX_IN  in  1  serial line, idle high, synchronized upstream
- PAR_EN  in  1  1 = frame carries a parity bit
- PAR_TYP  in  1  0 = even, 1 = odd
- prescale  in  PRESCALE_W  clocks per bit; legal values 8, 16, 32
- edge_cnt  in  PRESCALE_W  from counter
- bit_cnt  in  4  from counter
- enable  out  1  to counter; high while a frame is in progress
- new_frame  out  1  to counter; one-cycle pulse on start detection
- P_DATA  out  8  last good byte
- data_valid  out  1  one-cycle pulse when `P_DATA` updates
- par_err  out  1  parity error of the last frame
- stp_err  out  1  stop error of the last frame

Behaviour:
- Reset (asynchronous, `rst`=1):
  - state=IDLE.
  - `enable`, `new_frame`, `data_valid`, `par_err`, `stp_err` = 0.
  - `P_DATA`=0x00, shift register = 0, sample registers = 0.
  - Reset mid-frame aborts the frame with no `data_valid`.
- Config latch: `PAR_EN`/`PAR_TYP` are captured into local registers on `new_frame`. The integrator holds them stable for the whole frame, because the counter uses the live `PAR_EN`.
- Sampling (all states except IDLE), with mid = `prescale`>>1:
  - Store `RX_IN` at `edge_cnt`==mid-1 and at `edge_cnt`==mid.
  - At `edge_cnt`==mid+1, register sampled_bit = majority(s0, s1, `RX_IN`).
- Decision point: `edge_cnt`==`prescale` while `enable`=1. All state decisions below happen only there.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `enable`=0.
  - `RX_IN`==0 -> START, assert `enable` the next cycle, pulse `new_frame` for one cycle, clear `par_err`/`stp_err`.
- START (`bit_cnt`==0):
  - sampled_bit==1 -> glitch; IDLE, `enable` drops the next cycle, no error flags.
  - Else -> DATA.
- DATA (`bit_cnt` 1..8):
  - Shift right, sampled_bit into bit 7, so bit 0 ends up LSB-first.
  - At `bit_cnt`==8 -> PARITY if latched PAR_EN, else STOP.
- PARITY (`bit_cnt`==9):
  - expected = ^shift_reg XOR PAR_TYP.
  - par_err_int = (sampled_bit != expected); -> STOP.
- STOP (`bit_cnt`==9 without parity, 10 with parity):
  - `stp_err` = ~sampled_bit; `par_err` = par_err_int, registered the next cycle.
  - If neither error: `P_DATA` <= shift_reg and `data_valid`=1 for exactly one cycle; otherwise `P_DATA` is unchanged.
  - -> IDLE, `enable`=0 the next cycle.
- Latency: `data_valid` rises 1 clk after the stop-bit decision point.
- Back-to-back frames: `RX_IN` low in the first IDLE cycle after STOP starts a new frame. No idle gap is required.
- Error flags hold until the next `new_frame` or reset.
- Break condition (stop sampled 0 and line stays low): `stp_err`=1, then IDLE immediately sees `RX_IN`=0 and re-enters START; the counter restarts.
- `new_frame` and `data_valid` are never high in the same cycle.

Decomposition:
- Shared package `uart_rx_pkg`:
  - FSM state enum: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3-bit encoding.
  - Bit-index constants: START_BIT=0, LAST_DATA_BIT=8, PARITY_BIT=9, STOP_BIT_NOPAR=9, STOP_BIT_PAR=10.
  - Legal prescale constants 8/16/32.
- One natural sub-module, `uart_rx_sampler`: mid-bit three-sample majority vote. Inputs `clk`, `rst`, `RX_IN`, `edge_cnt`, `prescale`, `enable`; output sampled_bit.
- FSM, deserializer and checkers stay in this module.

Test Plan:
- prescale=8, PAR_EN=0, frame 0xA5 (0,1,0,1,0,0,1,0,1,1) -> `P_DATA`=0xA5, one `data_valid` pulse, `par_err`=`stp_err`=0, `enable` low after STOP.
- prescale=16, PAR_EN=1, PAR_TYP=0, byte 0x3C with parity bit 0 -> `P_DATA`=0x3C, `data_valid`. Same frame with parity bit 1 -> `par_err`=1, no `data_valid`, `P_DATA` stays 0x3C.
- prescale=8, `RX_IN` low for 2 clocks then high -> START rejects at decision point, IDLE, no `data_valid`, no error flags.
- prescale=8, byte 0x55 with stop bit 0 -> `stp_err`=1, no `data_valid`. Then a valid frame 0x0F -> flags clear on `new_frame`, `P_DATA`=0x0F.
- prescale=32, 1-clk inverted spike at `edge_cnt`==mid in data bit 3 of 0x81 -> majority rejects it, `P_DATA`=0x81.
- Two back-to-back frames 0x12, 0x34 with no idle gap -> two `data_valid` pulses in order. Assert `rst` mid second frame -> all outputs at reset values, no second pulse.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame controller.
// Bit indices follow the counter's bit_cnt numbering within one frame.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [3:0] START_BIT      = 4'd0;
  localparam logic [3:0] LAST_DATA_BIT  = 4'd8;
  localparam logic [3:0] PARITY_BIT     = 4'd9;
  localparam logic [3:0] STOP_BIT_NOPAR = 4'd9;
  localparam logic [3:0] STOP_BIT_PAR   = 4'd10;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Mid-bit sampler: three consecutive samples around the bit centre,
// majority-voted so a single-clock glitch cannot flip a bit.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  enable,
  output logic                  sampled_bit
);

  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] mid;
  logic [PRESCALE_W-1:0] mid_m1;
  logic [PRESCALE_W-1:0] mid_p1;
  logic                  s0;
  logic                  s1;

  // Legal ratios decode to constants; anything else falls back to the shift.
  always_comb begin
    case (prescale)
      PRESCALE_W'(PRESCALE_8):  mid = PRESCALE_W'(PRESCALE_8 / 2);
      PRESCALE_W'(PRESCALE_16): mid = PRESCALE_W'(PRESCALE_16 / 2);
      PRESCALE_W'(PRESCALE_32): mid = PRESCALE_W'(PRESCALE_32 / 2);
      default:                  mid = prescale >> 1;
    endcase
  end

  assign mid_m1 = mid - ONE;
  assign mid_p1 = mid + ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0          <= 1'b0;
      s1          <= 1'b0;
      sampled_bit <= 1'b0;
    end else if (enable) begin
      if (edge_cnt == mid_m1) s0 <= RX_IN;
      if (edge_cnt == mid)    s1 <= RX_IN;
      if (edge_cnt == mid_p1) sampled_bit <= majority3(s0, s1, RX_IN);
    end
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start validation, LSB-first deserialization,
// optional parity check and stop check, driven by the external edge/bit counter.
module uart_rx_frame_ctrl
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic [3:0]            bit_cnt,
  output logic                  enable,
  output logic                  new_frame,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  state_t                state;
  state_t                state_nxt;
  logic                  sampled_bit;
  logic                  decision;
  logic                  start_det;
  logic                  shift_en;
  logic                  par_chk;
  logic                  stop_chk;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  par_err_int;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [3:0]            stop_idx;

  assign enable   = (state != IDLE);
  assign decision = enable && (edge_cnt == prescale);
  assign stop_idx = par_en_q ? STOP_BIT_PAR : STOP_BIT_NOPAR;

  uart_rx_sampler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_sampler (
    .clk         (clk),
    .rst         (rst),
    .RX_IN       (RX_IN),
    .edge_cnt    (edge_cnt),
    .prescale    (prescale),
    .enable      (enable),
    .sampled_bit (sampled_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_det = 1'b0;
    shift_en  = 1'b0;
    par_chk   = 1'b0;
    stop_chk  = 1'b0;
    case (state)
      IDLE: begin
        if (!RX_IN) begin
          state_nxt = START;
          start_det = 1'b1;
        end
      end
      START: begin
        if (decision && bit_cnt == START_BIT)
          state_nxt = sampled_bit ? IDLE : DATA;
      end
      DATA: begin
        if (decision) begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_DATA_BIT)
            state_nxt = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (decision && bit_cnt == PARITY_BIT) begin
          par_chk   = 1'b1;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (decision && bit_cnt == stop_idx) begin
          stop_chk  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      new_frame   <= 1'b0;
      data_valid  <= 1'b0;
      P_DATA      <= '0;
      shift_reg   <= '0;
      par_en_q    <= 1'b0;
      par_typ_q   <= 1'b0;
      par_err_int <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
    end else begin
      new_frame  <= start_det;
      data_valid <= 1'b0;

      if (start_det) begin
        par_err     <= 1'b0;
        stp_err     <= 1'b0;
        par_err_int <= 1'b0;
      end

      if (new_frame) begin
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
      end

      if (shift_en)
        shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};

      if (par_chk)
        par_err_int <= (sampled_bit != ((^shift_reg) ^ par_typ_q));

      // A byte is only published when both the parity and the stop bit are good.
      if (stop_chk) begin
        stp_err <= ~sampled_bit;
        par_err <= par_err_int;
        if (sampled_bit && !par_err_int) begin
          P_DATA     <= shift_reg;
          data_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl with a behavioural edge/bit counter.
module tb_uart_rx_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] prescale;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       enable;
  logic       new_frame;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  int         checks = 0;
  int         errors = 0;
  int         dv_cnt = 0;
  int         nf_cnt = 0;
  logic [7:0] dv_log [16];
  logic [1:0] nf_flags = 2'b11;
  logic       overlap = 1'b0;

  always #5 clk = ~clk;

  uart_rx_frame_ctrl #(.PRESCALE_W(6), .DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .prescale   (prescale),
    .edge_cnt   (edge_cnt),
    .bit_cnt    (bit_cnt),
    .enable     (enable),
    .new_frame  (new_frame),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  // Edge/bit counter: edge_cnt runs 1..prescale per bit while enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (!enable) begin
      edge_cnt <= 6'd1;
      bit_cnt  <= 4'd0;
    end else if (edge_cnt == prescale) begin
      edge_cnt <= 6'd1;
      bit_cnt  <= bit_cnt + 4'd1;
    end else begin
      edge_cnt <= edge_cnt + 6'd1;
    end
  end

  always @(negedge clk) begin
    if (data_valid) begin
      if (dv_cnt < 16) dv_log[dv_cnt] = P_DATA;
      dv_cnt = dv_cnt + 1;
    end
    if (new_frame) begin
      nf_cnt   = nf_cnt + 1;
      nf_flags = {par_err, stp_err};
    end
    if (new_frame && data_valid) overlap = 1'b1;
  end

  task automatic idle_clks(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_level(input logic v, input int n);
    RX_IN = v;
    repeat (n) @(negedge clk);
  endtask

  // Frame of start, 8 data LSB-first, optional parity, stop; optional 1-clk spike.
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pb,
                            input logic sb, input int sp_bit, input int sp_off);
    logic [10:0] bits;
    int n;
    int p;
    p = int'(prescale);
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    if (pe) begin
      bits[9] = pb; bits[10] = sb; n = 11;
    end else begin
      bits[9] = sb; bits[10] = 1'b1; n = 10;
    end
    for (int k = 0; k < n; k++) begin
      for (int o = 0; o < p; o++) begin
        RX_IN = (k == sp_bit && o == sp_off) ? ~bits[k] : bits[k];
        @(negedge clk);
      end
    end
    RX_IN = 1'b1;
  endtask

  task automatic test_reset;
    checks++; if (enable !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b expected 0", enable); end
    checks++; if (new_frame !== 1'b0) begin errors++; $display("FAIL reset_new_frame: got %b expected 0", new_frame); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid: got %b expected 0", data_valid); end
    checks++; if (P_DATA !== 8'h00) begin errors++; $display("FAIL reset_pdata: got %h expected 00", P_DATA); end
    checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL reset_par_err: got %b expected 0", par_err); end
    checks++; if (stp_err !== 1'b0) begin errors++; $display("FAIL reset_stp_err: got %b expected 0", stp_err); end
    rst = 1'b0;
    idle_clks(4);
    checks++; if (enable !== 1'b0) begin errors++; $display("FAIL reset_idle_enable: got %b expected 0", enable); end
  endtask

  task automatic test_basic;
    int dv0;
    prescale = 6'd8; PAR_EN = 1'b0;
    dv0 = dv_cnt;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1, 0);
    idle_clks(5);
    checks++; if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL basic_dv_pulses: got %0d expected 1", dv_cnt - dv0); end
    checks++; if (P_DATA !== 8'hA5) begin errors++; $display("FAIL basic_pdata: got %h expected a5", P_DATA); end
    checks++; if (par_err !== 1'b0 || stp_err !== 1'b0) begin errors++; $display("FAIL basic_flags: got %b%b expected 00", par_err, stp_err); end
    checks++; if (enable !== 1'b0) begin errors++; $display("FAIL basic_enable: got %b expected 0", enable); end
  endtask

  task automatic test_parity;
    int dv0;
    prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    dv0 = dv_cnt;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, -1, 0);
    idle_clks(5);
    checks++; if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL parity_good_dv: got %0d expected 1", dv_cnt - dv0); end
    checks++; if (P_DATA !== 8'h3C || par_err !== 1'b0) begin errors++; $display("FAIL parity_good: got %h/%b expected 3c/0", P_DATA, par_err); end
    dv0 = dv_cnt;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, -1, 0);
    idle_clks(5);
    checks++; if (dv_cnt - dv0 !== 0) begin errors++; $display("FAIL parity_bad_dv: got %0d expected 0", dv_cnt - dv0); end
    checks++; if (par_err !== 1'b1) begin errors++; $display("FAIL parity_bad_par_err: got %b expected 1", par_err); end
    checks++; if (stp_err !== 1'b0) begin errors++; $display("FAIL parity_bad_stp_err: got %b expected 0", stp_err); end
    checks++; if (P_DATA !== 8'h3C) begin errors++; $display("FAIL parity_bad_pdata: got %h expected 3c", P_DATA); end
    PAR_EN = 1'b0;
  endtask

  task automatic test_glitch;
    int dv0;
    int nf0;
    prescale = 6'd8;
    dv0 = dv_cnt; nf0 = nf_cnt;
    drive_level(1'b0, 2);
    idle_clks(24);
    checks++; if (nf_cnt - nf0 !== 1) begin errors++; $display("FAIL glitch_new_frame: got %0d expected 1", nf_cnt - nf0); end
    checks++; if (dv_cnt - dv0 !== 0) begin errors++; $display("FAIL glitch_dv: got %0d expected 0", dv_cnt - dv0); end
    checks++; if (par_err !== 1'b0 || stp_err !== 1'b0) begin errors++; $display("FAIL glitch_flags: got %b%b expected 00", par_err, stp_err); end
    checks++; if (enable !== 1'b0) begin errors++; $display("FAIL glitch_enable: got %b expected 0", enable); end
  endtask

  task automatic test_stop_err;
    int dv0;
    prescale = 6'd8;
    dv0 = dv_cnt;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, -1, 0);
    idle_clks(6);
    checks++; if (stp_err !== 1'b1) begin errors++; $display("FAIL stop_err_flag: got %b expected 1", stp_err); end
    checks++; if (dv_cnt - dv0 !== 0) begin errors++; $display("FAIL stop_err_dv: got %0d expected 0", dv_cnt - dv0); end
    checks++; if (P_DATA !== 8'h3C) begin errors++; $display("FAIL stop_err_pdata: got %h expected 3c", P_DATA); end
    dv0 = dv_cnt;
    send_frame(8'h0F, 1'b0, 1'b0, 1'b1, -1, 0);
    idle_clks(6);
    checks++; if (nf_flags !== 2'b00) begin errors++; $display("FAIL stop_recover_clear: got %b expected 00", nf_flags); end
    checks++; if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL stop_recover_dv: got %0d expected 1", dv_cnt - dv0); end
    checks++; if (P_DATA !== 8'h0F) begin errors++; $display("FAIL stop_recover_pdata: got %h expected 0f", P_DATA); end
    checks++; if (stp_err !== 1'b0) begin errors++; $display("FAIL stop_recover_stp_err: got %b expected 0", stp_err); end
  endtask

  task automatic test_spike;
    int dv0;
    prescale = 6'd32;
    dv0 = dv_cnt;
    // Data bit 3 is frame bit 4; spike lands where edge_cnt equals 16.
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 4, 16);
    idle_clks(6);
    checks++; if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL spike_dv: got %0d expected 1", dv_cnt - dv0); end
    checks++; if (P_DATA !== 8'h81) begin errors++; $display("FAIL spike_pdata: got %h expected 81", P_DATA); end
  endtask

  task automatic test_back_to_back;
    int dv0;
    prescale = 6'd16;
    dv0 = dv_cnt;
    overlap = 1'b0;
    send_frame(8'h12, 1'b0, 1'b0, 1'b1, -1, 0);
    send_frame(8'h34, 1'b0, 1'b0, 1'b1, -1, 0);
    idle_clks(8);
    checks++; if (dv_cnt - dv0 !== 2) begin errors++; $display("FAIL b2b_dv_count: got %0d expected 2", dv_cnt - dv0); end
    checks++; if (dv_log[dv0] !== 8'h12) begin errors++; $display("FAIL b2b_first: got %h expected 12", dv_log[dv0]); end
    checks++; if (dv_log[dv0+1] !== 8'h34) begin errors++; $display("FAIL b2b_second: got %h expected 34", dv_log[dv0+1]); end
    checks++; if (overlap !== 1'b0) begin errors++; $display("FAIL b2b_overlap: got %b expected 0", overlap); end
  endtask

  task automatic test_reset_mid_frame;
    int dv0;
    prescale = 6'd16;
    dv0 = dv_cnt;
    send_frame(8'h12, 1'b0, 1'b0, 1'b1, -1, 0);
    drive_level(1'b0, 16);
    drive_level(1'b0, 16);
    drive_level(1'b0, 16);
    drive_level(1'b1, 16);
    checks++; if (enable !== 1'b1) begin errors++; $display("FAIL midrst_enable_before: got %b expected 1", enable); end
    checks++; if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL midrst_first_dv: got %0d expected 1", dv_cnt - dv0); end
    rst = 1'b1;
    #2;
    checks++; if (enable !== 1'b0 || new_frame !== 1'b0 || data_valid !== 1'b0) begin errors++; $display("FAIL midrst_ctrl: got en=%b nf=%b dv=%b expected 000", enable, new_frame, data_valid); end
    checks++; if (P_DATA !== 8'h00) begin errors++; $display("FAIL midrst_pdata: got %h expected 00", P_DATA); end
    checks++; if (par_err !== 1'b0 || stp_err !== 1'b0) begin errors++; $display("FAIL midrst_flags: got %b%b expected 00", par_err, stp_err); end
    @(negedge clk);
    RX_IN = 1'b1;
    rst = 1'b0;
    idle_clks(120);
    checks++; if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL midrst_no_second_dv: got %0d expected 1", dv_cnt - dv0); end
    checks++; if (enable !== 1'b0) begin errors++; $display("FAIL midrst_enable_after: got %b expected 0", enable); end
  endtask

  initial begin
    rst = 1'b1;
    RX_IN = 1'b1;
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    prescale = 6'd8;
    repeat (3) @(negedge clk);
    test_reset;
    test_basic;
    test_parity;
    test_glitch;
    test_stop_err;
    test_spike;
    test_back_to_back;
    test_reset_mid_frame;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
